// File: rtl/nebula_wb_pkg.sv
// Shared types and constants for the Wishbone initiator blocks.
package nebula_wb_pkg;

    // Initiator cycle state: waiting for a command, driving the bus, holding a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    // Default number of strobe cycles allowed before giving up on an ack.
    localparam int DEFAULT_TIMEOUT = 255;

    // Read data returned when a cycle times out.
    localparam int ERR_RDATA = 0;

endpackage : nebula_wb_pkg

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter that flags when the final allowed strobe cycle is reached.
module wb_timeout_counter
    import nebula_wb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_reg;

    // Count strobe cycles; stop at the last value so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    assign expired = (count_reg == LAST_COUNT);

endmodule : wb_timeout_counter

// File: rtl/wb_master_ctrl.sv
// Single-transaction Wishbone classic initiator with command/response handshakes
// and a bounded wait for the slave acknowledge.
module wb_master_ctrl
    import nebula_wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    // command channel
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    // response channel
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic                rsp_err_o,
    // Wishbone initiator port
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    // status
    output logic                busy_o
);

    localparam int SEL_W = DATA_W / 8;

    wbm_state_t          state_reg,     state_next;
    logic                cyc_reg,       cyc_next;
    logic                stb_reg,       stb_next;
    logic                we_reg,        we_next;
    logic [SEL_W-1:0]    sel_reg,       sel_next;
    logic [ADDR_W-1:0]   adr_reg,       adr_next;
    logic [DATA_W-1:0]   dat_reg,       dat_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_dat_reg,   rsp_dat_next;
    logic                rsp_err_reg,   rsp_err_next;

    logic                cmd_ready;
    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expired;

    // A command is only taken in IDLE and never while reset is asserted.
    assign cmd_ready = (state_reg == IDLE) && wb_rst_i;

    // Counts strobe cycles of the current bus cycle.
    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and registered-output logic for the IDLE -> BUS -> RESP cycle.
    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        stb_next       = stb_reg;
        we_next        = we_reg;
        sel_next       = sel_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
        rsp_err_next   = rsp_err_reg;
        timer_clear    = 1'b0;
        timer_enable   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid_i && cmd_ready) begin
                    we_next     = cmd_we_i;
                    sel_next    = cmd_sel_i;
                    adr_next    = cmd_adr_i;
                    // Reads never drive stale write data onto the bus.
                    dat_next    = cmd_we_i ? cmd_dat_i : '0;
                    cyc_next    = 1'b1;
                    stb_next    = 1'b1;
                    timer_clear = 1'b1;
                    state_next  = BUS;
                end
            end

            BUS: begin
                // Ack is checked first so an ack on the last allowed cycle still succeeds.
                if (wbm_ack_i) begin
                    rsp_dat_next   = we_reg ? '0 : wbm_dat_i;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    state_next     = RESP;
                end else if (timer_expired) begin
                    rsp_dat_next   = DATA_W'(ERR_RDATA);
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    state_next     = RESP;
                end else begin
                    timer_enable   = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any cycle or response in flight.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_reg     <= IDLE;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            sel_reg       <= '0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            stb_reg       <= stb_next;
            we_reg        <= we_next;
            sel_reg       <= sel_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready_o = cmd_ready;
    assign wbm_cyc_o   = cyc_reg;
    assign wbm_stb_o   = stb_reg;
    assign wbm_we_o    = we_reg;
    assign wbm_sel_o   = sel_reg;
    assign wbm_adr_o   = adr_reg;
    assign wbm_dat_o   = dat_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_dat_o   = rsp_dat_reg;
    assign rsp_err_o   = rsp_err_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule : wb_master_ctrl

// File: tb/tb_wb_master_ctrl.sv
// Self-checking bench for wb_master_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-count reference model.
module tb_wb_master_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = DATA_W / 8;
    localparam int TIMEOUT = 8;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [ADDR_W-1:0] cmd_adr_i;
    logic [DATA_W-1:0] cmd_dat_i;
    logic [SEL_W-1:0]  cmd_sel_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_dat_o;
    logic              rsp_err_o;
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic              wbm_ack_i;
    logic [DATA_W-1:0] wbm_dat_i;
    logic              busy_o;

    int assert_count = 0;
    int fail_count   = 0;

    wb_master_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .busy_o      (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Observations collected over one complete transaction.
    typedef struct {
        int                stb_cycles;
        bit                hold_bad;
        logic              first_we;
        logic [SEL_W-1:0]  first_sel;
        logic [ADDR_W-1:0] first_adr;
        logic [DATA_W-1:0] first_dat;
        logic              ready_at_start;
        logic              rsp_valid;
        logic              rsp_err;
        logic [DATA_W-1:0] rsp_dat;
        logic              cyc_in_resp;
        bit                rsp_unstable;
        bit                ready_in_resp;
        bit                busy_in_resp;
        logic              valid_after;
        logic              busy_after;
        logic              ready_after;
        logic              stb_after;
    } txn_obs_t;

    // Reference model: the slave acks in strobe cycle wait_c+1; anything past TIMEOUT is a timeout.
    function automatic int model_stb(input int wait_c);
        return (wait_c < TIMEOUT) ? wait_c + 1 : TIMEOUT;
    endfunction

    function automatic logic model_err(input int wait_c);
        return (wait_c >= TIMEOUT);
    endfunction

    function automatic logic [DATA_W-1:0] model_dat(input logic we, input int wait_c,
                                                    input logic [DATA_W-1:0] rdata);
        if (we || wait_c >= TIMEOUT) return '0;
        return rdata;
    endfunction

    // Drive one command, play the slave, hold the response for rsp_delay cycles, then consume it.
    // Starts and ends just after a falling edge.
    task automatic do_txn(input logic we, input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat,
                          input logic [SEL_W-1:0] sel, input int wait_c, input logic [DATA_W-1:0] rdata,
                          input int rsp_delay, input bit spurious, input bit next_valid,
                          output txn_obs_t obs);
        obs = '{default: '0};
        obs.busy_in_resp = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        cmd_sel_i   = sel;
        cmd_valid_i = 1'b1;
        obs.ready_at_start = cmd_ready_o;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_dat_i   = $urandom;
        while (wbm_stb_o === 1'b1 && obs.stb_cycles < TIMEOUT + 4) begin
            obs.stb_cycles++;
            if (obs.stb_cycles == 1) begin
                obs.first_we  = wbm_we_o;
                obs.first_sel = wbm_sel_o;
                obs.first_adr = wbm_adr_o;
                obs.first_dat = wbm_dat_o;
            end else if (wbm_we_o !== obs.first_we || wbm_sel_o !== obs.first_sel ||
                         wbm_adr_o !== obs.first_adr || wbm_dat_o !== obs.first_dat) begin
                obs.hold_bad = 1'b1;
            end
            if (wbm_cyc_o !== 1'b1) obs.hold_bad = 1'b1;
            wbm_ack_i = (obs.stb_cycles - 1 == wait_c);
            wbm_dat_i = wbm_ack_i ? rdata : $urandom;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
        obs.rsp_valid     = rsp_valid_o;
        obs.rsp_err       = rsp_err_o;
        obs.rsp_dat       = rsp_dat_o;
        obs.cyc_in_resp   = wbm_cyc_o | wbm_stb_o;
        obs.ready_in_resp = cmd_ready_o;
        obs.busy_in_resp  = busy_o;
        for (int i = 0; i < rsp_delay; i++) begin
            if (next_valid) begin
                cmd_valid_i = 1'b1;
                cmd_adr_i   = adr + 32'h10;
            end
            wbm_ack_i = spurious && (i == 1);
            wbm_dat_i = $urandom;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            if (rsp_valid_o !== obs.rsp_valid || rsp_err_o !== obs.rsp_err || rsp_dat_o !== obs.rsp_dat)
                obs.rsp_unstable = 1'b1;
            obs.ready_in_resp = obs.ready_in_resp | cmd_ready_o;
            obs.busy_in_resp  = obs.busy_in_resp & busy_o;
        end
        rsp_ready_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        obs.valid_after = rsp_valid_o;
        obs.busy_after  = busy_o;
        obs.ready_after = cmd_ready_o;
        obs.stb_after   = wbm_stb_o;
        $display("txn we=%0d adr=%h wait=%0d delay=%0d -> stb_cycles=%0d valid=%0d err=%0d dat=%h",
                 we, adr, wait_c, rsp_delay, obs.stb_cycles, obs.rsp_valid, obs.rsp_err, obs.rsp_dat);
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        assert_count++;
        if (cmd_ready_o !== 1'b0) begin
            fail_count++; $display("FAIL reset_cmd_ready_low: got %b expected 0", cmd_ready_o);
        end
        assert_count++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o, busy_o} !== 6'b0) begin
            fail_count++; $display("FAIL reset_ctrl_outputs: got %b expected 000000",
                                   {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o, busy_o});
        end
        assert_count++;
        if ({wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat_o} !== '0) begin
            fail_count++; $display("FAIL reset_data_outputs: adr=%h dat=%h sel=%h rdat=%h expected all 0",
                                   wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_dat_o);
        end
        wb_rst_i = 1'b1;
        #1;
        assert_count++;
        if (cmd_ready_o !== 1'b1) begin
            fail_count++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready_o);
        end
        @(negedge wb_clk_i);
    endtask

    task automatic test_zero_wait_write();
        txn_obs_t obs;
        do_txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, obs);
        assert_count++;
        if (obs.stb_cycles != model_stb(0)) begin
            fail_count++; $display("FAIL zw_stb_cycles: got %0d expected %0d", obs.stb_cycles, model_stb(0));
        end
        assert_count++;
        if ({obs.first_we, obs.first_sel, obs.first_adr, obs.first_dat} !== {1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_1234}) begin
            fail_count++; $display("FAIL zw_bus_values: we=%b sel=%h adr=%h dat=%h expected 1 f 30000004 a5a51234",
                                   obs.first_we, obs.first_sel, obs.first_adr, obs.first_dat);
        end
        assert_count++;
        if ({obs.rsp_valid, obs.rsp_err, obs.rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
            fail_count++; $display("FAIL zw_response: valid=%b err=%b dat=%h expected 1 0 00000000",
                                   obs.rsp_valid, obs.rsp_err, obs.rsp_dat);
        end
        assert_count++;
        if (obs.cyc_in_resp !== 1'b0) begin
            fail_count++; $display("FAIL zw_cyc_dropped: got %b expected 0", obs.cyc_in_resp);
        end
    endtask

    task automatic test_wait_read();
        txn_obs_t obs;
        do_txn(1'b0, 32'h1000_0020, 32'h1234_5678, 4'h3, 3, 32'hCAFE_0001, 0, 1'b0, 1'b0, obs);
        assert_count++;
        if (obs.stb_cycles != model_stb(3)) begin
            fail_count++; $display("FAIL wr_stb_cycles: got %0d expected %0d", obs.stb_cycles, model_stb(3));
        end
        assert_count++;
        if (obs.first_dat !== 32'h0 || obs.hold_bad) begin
            fail_count++; $display("FAIL wr_bus_dat_zero: dat=%h hold_bad=%0d expected 00000000 and 0",
                                   obs.first_dat, obs.hold_bad);
        end
        assert_count++;
        if ({obs.rsp_err, obs.rsp_dat} !== {model_err(3), model_dat(1'b0, 3, 32'hCAFE_0001)}) begin
            fail_count++; $display("FAIL wr_response: err=%b dat=%h expected 0 cafe0001", obs.rsp_err, obs.rsp_dat);
        end
    endtask

    task automatic test_timeout();
        txn_obs_t obs;
        do_txn(1'b0, 32'h2000_0000, 32'h0, 4'hF, 1000, 32'h5555_AAAA, 2, 1'b0, 1'b0, obs);
        assert_count++;
        if (obs.stb_cycles != TIMEOUT) begin
            fail_count++; $display("FAIL to_stb_cycles: got %0d expected %0d", obs.stb_cycles, TIMEOUT);
        end
        assert_count++;
        if ({obs.rsp_valid, obs.rsp_err, obs.rsp_dat} !== {1'b1, 1'b1, 32'h0}) begin
            fail_count++; $display("FAIL to_response: valid=%b err=%b dat=%h expected 1 1 00000000",
                                   obs.rsp_valid, obs.rsp_err, obs.rsp_dat);
        end
        assert_count++;
        if (obs.busy_in_resp !== 1'b1 || obs.busy_after !== 1'b0) begin
            fail_count++; $display("FAIL to_busy_fall: in_resp=%b after=%b expected 1 0",
                                   obs.busy_in_resp, obs.busy_after);
        end
    endtask

    task automatic test_ack_last_cycle();
        txn_obs_t obs;
        do_txn(1'b0, 32'h2000_0008, 32'h0, 4'hC, TIMEOUT - 1, 32'h0BAD_F00D, 0, 1'b0, 1'b0, obs);
        assert_count++;
        if (obs.stb_cycles != TIMEOUT) begin
            fail_count++; $display("FAIL al_stb_cycles: got %0d expected %0d", obs.stb_cycles, TIMEOUT);
        end
        assert_count++;
        if ({obs.rsp_err, obs.rsp_dat} !== {1'b0, 32'h0BAD_F00D}) begin
            fail_count++; $display("FAIL al_response: err=%b dat=%h expected 0 0badf00d", obs.rsp_err, obs.rsp_dat);
        end
    endtask

    task automatic test_back_to_back();
        txn_obs_t obs;
        txn_obs_t obs2;
        do_txn(1'b1, 32'h4000_0000, 32'h1111_2222, 4'h1, 2, 32'h0, 5, 1'b1, 1'b1, obs);
        assert_count++;
        if (obs.rsp_unstable || obs.rsp_valid !== 1'b1) begin
            fail_count++; $display("FAIL bp_rsp_stable: unstable=%0d valid=%b expected 0 1", obs.rsp_unstable, obs.rsp_valid);
        end
        assert_count++;
        if (obs.ready_in_resp !== 1'b0 || obs.busy_in_resp !== 1'b1) begin
            fail_count++; $display("FAIL bp_ready_low: ready=%b busy=%b expected 0 1", obs.ready_in_resp, obs.busy_in_resp);
        end
        assert_count++;
        if ({obs.valid_after, obs.ready_after, obs.stb_after} !== 3'b010) begin
            fail_count++; $display("FAIL bp_handshake: valid=%b ready=%b stb=%b expected 0 1 0",
                                   obs.valid_after, obs.ready_after, obs.stb_after);
        end
        do_txn(1'b0, 32'h4000_0010, 32'h0, 4'hF, 0, 32'h7777_8888, 0, 1'b0, 1'b0, obs2);
        assert_count++;
        if (obs2.stb_cycles != 1 || obs2.first_adr !== 32'h4000_0010) begin
            fail_count++; $display("FAIL bp_second_accept: stb_cycles=%0d adr=%h expected 1 40000010",
                                   obs2.stb_cycles, obs2.first_adr);
        end
        assert_count++;
        if (obs2.rsp_dat !== 32'h7777_8888) begin
            fail_count++; $display("FAIL bp_second_data: got %h expected 77778888", obs2.rsp_dat);
        end
    endtask

    task automatic test_reset_mid_bus();
        bit saw_valid = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h5000_0000;
        cmd_sel_i   = 4'hF;
        cmd_valid_i = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        assert_count++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o} !== 4'b0) begin
            fail_count++; $display("FAIL rb_outputs_cleared: cyc=%b stb=%b valid=%b busy=%b expected 0 0 0 0",
                                   wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o);
        end
        wb_rst_i = 1'b1;
        #1;
        assert_count++;
        if (cmd_ready_o !== 1'b1) begin
            fail_count++; $display("FAIL rb_ready_after: got %b expected 1", cmd_ready_o);
        end
        wbm_ack_i = 1'b1;
        repeat (4) begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            saw_valid = saw_valid | rsp_valid_o;
        end
        assert_count++;
        if (saw_valid) begin
            fail_count++; $display("FAIL rb_no_response: got valid 1 expected 0");
        end
        $display("txn reset-during-bus adr=50000000 -> discarded");
    endtask

    task automatic test_random();
        txn_obs_t obs;
        for (int n = 0; n < 24; n++) begin
            logic              we     = 1'($urandom);
            logic [ADDR_W-1:0] adr    = $urandom;
            logic [DATA_W-1:0] dat    = $urandom;
            logic [SEL_W-1:0]  sel    = 4'($urandom);
            logic [DATA_W-1:0] rdata  = $urandom;
            int                wait_c = $urandom_range(0, TIMEOUT + 2);
            int                delay  = $urandom_range(0, 3);
            do_txn(we, adr, dat, sel, wait_c, rdata, delay, 1'b0, 1'b0, obs);
            assert_count++;
            if (obs.stb_cycles != model_stb(wait_c) || obs.hold_bad) begin
                fail_count++; $display("FAIL rnd%0d_stb: cycles=%0d hold_bad=%0d expected %0d 0",
                                       n, obs.stb_cycles, obs.hold_bad, model_stb(wait_c));
            end
            assert_count++;
            if ({obs.first_we, obs.first_sel, obs.first_adr, obs.first_dat} !== {we, sel, adr, we ? dat : 32'h0}) begin
                fail_count++; $display("FAIL rnd%0d_bus: we=%b sel=%h adr=%h dat=%h expected %b %h %h %h", n,
                                       obs.first_we, obs.first_sel, obs.first_adr, obs.first_dat, we, sel, adr, we ? dat : 32'h0);
            end
            assert_count++;
            if ({obs.rsp_valid, obs.rsp_err, obs.rsp_dat} !== {1'b1, model_err(wait_c), model_dat(we, wait_c, rdata)}) begin
                fail_count++; $display("FAIL rnd%0d_rsp: valid=%b err=%b dat=%h expected 1 %b %h", n,
                                       obs.rsp_valid, obs.rsp_err, obs.rsp_dat, model_err(wait_c), model_dat(we, wait_c, rdata));
            end
            assert_count++;
            if (obs.rsp_unstable || {obs.valid_after, obs.busy_after, obs.ready_after} !== 3'b001) begin
                fail_count++; $display("FAIL rnd%0d_handshake: unstable=%0d valid=%b busy=%b ready=%b expected 0 0 0 1", n,
                                       obs.rsp_unstable, obs.valid_after, obs.busy_after, obs.ready_after);
            end
        end
    endtask

    initial begin
        wb_rst_i    = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_dat_i   = '0;
        @(negedge wb_clk_i);
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_timeout();
        test_ack_last_cycle();
        test_back_to_back();
        test_reset_mid_bus();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Hard stop in case the design stalls the bench.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_wb_master_ctrl
